// File: rtl/pm_loader_ifc_if.sv
// Bundles the sequencer fetch port, the loader stream and the status outputs of the program-memory loader.
interface pm_loader_ifc_if;
    logic        ps_pm_cslt;
    logic        ps_pm_wrb;
    logic [15:0] ps_pm_add;
    logic [31:0] pm_ps_op;
    logic        pm_ps_stallb;
    logic        boot_req;
    logic        ld_vld;
    logic [31:0] ld_dt;
    logic        ld_last;
    logic [31:0] ld_chk;
    logic        ld_rdy;
    logic        pm_ld_err;
    logic        pm_acc_err;
    logic [1:0]  pm_state;

    modport master (
        output ps_pm_cslt, ps_pm_wrb, ps_pm_add, boot_req,
        output ld_vld, ld_dt, ld_last, ld_chk,
        input  pm_ps_op, pm_ps_stallb, ld_rdy, pm_ld_err, pm_acc_err, pm_state
    );

    modport slave (
        input  ps_pm_cslt, ps_pm_wrb, ps_pm_add, boot_req,
        input  ld_vld, ld_dt, ld_last, ld_chk,
        output pm_ps_op, pm_ps_stallb, ld_rdy, pm_ld_err, pm_acc_err, pm_state
    );
endinterface

// File: rtl/pm_loader_ifc.sv
// Program-memory loader and instruction-fetch front end: a checksummed loader stream fills the
// memory, after which the sequencer fetches instruction words with one cycle of latency.
module pm_loader_ifc #(
    parameter int PM_AW = 8
) (
    input  logic           clk_fetch,
    input  logic           rst,
    pm_loader_ifc_if.slave bus
);
    typedef enum logic [1:0] {LOAD = 2'b00, RUN = 2'b01, ERR = 2'b10} state_t;
    localparam int DEPTH = 1 << PM_AW;

    state_t         state, state_nxt;
    logic [PM_AW:0] wcnt, wcnt_nxt;
    logic [31:0]    sum, sum_nxt;
    logic [31:0]    op, op_nxt;
    logic           ld_err, ld_err_nxt;
    logic           acc_err, acc_err_nxt;
    logic [31:0]    mem [DEPTH];

    logic           in_run, in_err, in_load;
    logic           hs, full, fetch_ok, mem_we;
    logic [31:0]    sum_new;

    // The unused code 11 falls through to LOAD everywhere it is decoded.
    assign in_run   = (state == RUN);
    assign in_err   = (state == ERR);
    assign in_load  = !(in_run || in_err);
    assign hs       = bus.ld_vld && in_load;
    assign full     = wcnt[PM_AW];
    assign sum_new  = sum + bus.ld_dt;
    assign fetch_ok = !bus.ps_pm_wrb && ((bus.ps_pm_add >> PM_AW) == 16'd0);
    assign mem_we   = hs && !full;

    always_ff @(posedge clk_fetch or negedge rst) begin
        if (!rst) begin
            state   <= LOAD;
            wcnt    <= '0;
            sum     <= '0;
            op      <= '0;
            ld_err  <= 1'b0;
            acc_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            wcnt    <= wcnt_nxt;
            sum     <= sum_nxt;
            op      <= op_nxt;
            ld_err  <= ld_err_nxt;
            acc_err <= acc_err_nxt;
        end
    end

    // Memory contents deliberately survive reset; only a reload replaces them.
    always_ff @(posedge clk_fetch) begin
        if (mem_we) begin
            mem[wcnt[PM_AW-1:0]] <= bus.ld_dt;
        end
    end

    always_comb begin
        state_nxt   = state;
        wcnt_nxt    = wcnt;
        sum_nxt     = sum;
        op_nxt      = 32'd0;
        ld_err_nxt  = ld_err;
        acc_err_nxt = acc_err;
        case (state)
            RUN: begin
                op_nxt = op;
                if (bus.boot_req) begin
                    state_nxt   = LOAD;
                    wcnt_nxt    = '0;
                    sum_nxt     = '0;
                    op_nxt      = 32'd0;
                    ld_err_nxt  = 1'b0;
                    acc_err_nxt = 1'b0;
                end else if (bus.ps_pm_cslt) begin
                    if (fetch_ok) begin
                        op_nxt = mem[bus.ps_pm_add[PM_AW-1:0]];
                    end else begin
                        op_nxt      = 32'd0;
                        acc_err_nxt = 1'b1;
                    end
                end
            end
            ERR: begin
                if (bus.boot_req) begin
                    state_nxt   = LOAD;
                    wcnt_nxt    = '0;
                    sum_nxt     = '0;
                    ld_err_nxt  = 1'b0;
                    acc_err_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = LOAD;
                if (hs) begin
                    if (full) begin
                        state_nxt  = ERR;
                        ld_err_nxt = 1'b1;
                    end else begin
                        wcnt_nxt = wcnt + (PM_AW + 1)'(1);
                        sum_nxt  = sum_new;
                        if (bus.ld_last) begin
                            if (sum_new == bus.ld_chk) begin
                                state_nxt = RUN;
                            end else begin
                                state_nxt  = ERR;
                                ld_err_nxt = 1'b1;
                            end
                        end
                    end
                end
            end
        endcase
    end

    assign bus.pm_ps_op     = op;
    assign bus.pm_ps_stallb = in_run;
    assign bus.ld_rdy       = in_load;
    assign bus.pm_ld_err    = ld_err;
    assign bus.pm_acc_err   = acc_err;
    assign bus.pm_state     = in_load ? 2'b00 : 2'(state);
endmodule
